// File: rtl/gates2_pkg.sv
// gates2_pkg
//   Shared definitions for the gates2 logic-gate block and its built-in self
//   test: FSM state encoding, bit positions of each gate output inside z, the
//   stimulus table driven onto {a,b} and the expected z for each vector.
package gates2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bit position of each gate output within z[5:0]
  localparam int Z_AND  = 5;
  localparam int Z_NAND = 4;
  localparam int Z_OR   = 3;
  localparam int Z_NOR  = 2;
  localparam int Z_XOR  = 1;
  localparam int Z_XNOR = 0;

  localparam int NUM_VEC = 4;

  // Stimulus order as {a,b}
  localparam logic [1:0] VEC_AB [0:NUM_VEC-1] = '{2'b00, 2'b10, 2'b01, 2'b11};

  // Expected z for each stimulus vector
  localparam logic [5:0] EXP_VEC [0:NUM_VEC-1] = '{6'h15, 6'h1A, 6'h1A, 6'h29};

endpackage

// File: rtl/gates2_if.sv
// gates2_if
//   Operand/result bus between the self-test driver and the gates2 block.
//   Signals:
//     a, b  operands, driven by the master (self test)
//     z     six gate outputs, driven by the slave (gates2)
interface gates2_if;
  logic       a;
  logic       b;
  logic [5:0] z;

  modport master (output a, output b, input z);
  modport slave  (input a, input b, output z);
endinterface

// File: rtl/gates2.sv
// gates2
//   Purely combinational two-input logic-gate block.
//   Ports:
//     bus (slave)  a, b in; z[5:0] out = {and,nand,or,nor,xor,xnor}
module gates2
  import gates2_pkg::*;
(
  gates2_if.slave bus
);

  assign bus.z[Z_AND]  = bus.a & bus.b;
  assign bus.z[Z_NAND] = ~(bus.a & bus.b);
  assign bus.z[Z_OR]   = bus.a | bus.b;
  assign bus.z[Z_NOR]  = ~(bus.a | bus.b);
  assign bus.z[Z_XOR]  = bus.a ^ bus.b;
  assign bus.z[Z_XNOR] = ~(bus.a ^ bus.b);

endmodule

// File: rtl/gates2_selftest.sv
// gates2_selftest
//   Built-in self test for gates2: on start, walks {a,b} through the four
//   input vectors, waits SETTLE_CYCLES after each change, then compares z with
//   the expected truth-table entry and accumulates the result.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      begin a run (only honoured in IDLE)
//     bus        master side of gates2_if: a/b out (registered), z in
//     busy       high from start acceptance until DONE is left
//     done       one-cycle pulse in the DONE state
//     pass       set when the run had no mismatches; held until next start
//     err_count  number of mismatching vectors in the last run
//     fail_vec   bit i set if vector i mismatched
module gates2_selftest
  import gates2_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  gates2_if.master       bus,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2:0]     err_count,
  output logic [3:0]     fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_DRIVE: begin
        {a_d, b_d} = VEC_AB[idx_q];
        cnt_d      = SETTLE_INIT;
        state_d    = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end

      ST_SETTLE: begin
        // Leaving on the count of 1 makes SETTLE last exactly SETTLE_CYCLES cycles
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (bus.z != EXP_VEC[idx_q]) begin
          err_d         = err_q + 3'd1;
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          // Latch the verdict on entry to DONE so pass is valid alongside done
          state_d = ST_DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign busy      = busy_q;
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gates2_selftest.sv
// tb_gates2_selftest
//   Two self-test instances (default settle time and zero settle time), each
//   paired with a real gates2; the z path between them can be corrupted with
//   an AND mask and an OR mask to plant faults.
module tb_gates2_selftest;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  logic [5:0] am0, om0, am1, om1;

  gates2_if st0 ();
  gates2_if g0  ();
  gates2_if st1 ();
  gates2_if g1  ();

  assign g0.a  = st0.a;
  assign g0.b  = st0.b;
  assign st0.z = (g0.z & am0) | om0;
  assign g1.a  = st1.a;
  assign g1.b  = st1.b;
  assign st1.z = (g1.z & am1) | om1;

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fv0, fv1;

  gates2_selftest #(.SETTLE_CYCLES(4), .CNT_W(4)) u_st0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(st0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );
  gates2 u_g0 (.bus(g0));

  gates2_selftest #(.SETTLE_CYCLES(0), .CNT_W(4)) u_st1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(st1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );
  gates2 u_g1 (.bus(g1));

  // View of whichever instance the current run targets
  logic       sel;
  logic       s_a, s_b, s_busy, s_done, s_pass;
  logic [2:0] s_err;
  logic [3:0] s_fv;
  assign s_a    = sel ? st1.a : st0.a;
  assign s_b    = sel ? st1.b : st0.b;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;
  assign s_pass = sel ? pass1 : pass0;
  assign s_err  = sel ? err1  : err0;
  assign s_fv   = sel ? fv1   : fv0;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: gate definitions straight from boolean algebra
  function automatic logic [5:0] truth(input logic a, input logic b);
    return {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  // Expected run verdict for a given z corruption. Vector i is {a,b} with
  // a = i mod 2 and b = i div 2, giving the order 00,10,01,11.
  task automatic model(input logic [5:0] am, input logic [5:0] om,
                       output int e, output int fv, output int p);
    logic [5:0] t;
    e  = 0;
    fv = 0;
    for (int i = 0; i < 4; i++) begin
      t = truth(logic'(i % 2), logic'(i / 2));
      if (((t & am) | om) != t) begin
        e++;
        fv = fv | (1 << i);
      end
    end
    p = (e == 0) ? 1 : 0;
  endtask

  // Pulse start on the selected instance and observe the whole run.
  // Cycle c is the c-th clock period after the start-accepting edge.
  task automatic run(input logic which, input int settle, input int exp_err,
                     input int exp_fv, input int exp_pass, input int extra_start,
                     input string tag);
    int exp_cyc;
    int done_cyc, done_n, busy_n, ab_bad;
    int got_err, got_fv, got_pass;
    exp_cyc  = 4 * (settle + 2) + 1;
    done_cyc = 0;
    done_n   = 0;
    busy_n   = 0;
    ab_bad   = 0;
    got_err  = -1;
    got_fv   = -1;
    got_pass = -1;
    sel = which;
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 1; c <= exp_cyc + 4; c++) begin
      if (extra_start > 0 && c == extra_start) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
      if (extra_start > 0 && c == extra_start + 1) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (s_busy) busy_n++;
      if (s_done) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = c;
          got_err  = int'(s_err);
          got_fv   = int'(s_fv);
          got_pass = int'(s_pass);
        end
      end
      // Operands must hold vector i when z for vector i is judged
      for (int i = 0; i < 4; i++) begin
        if (c == (i + 1) * (settle + 2)) begin
          if (s_a != logic'(i % 2) || s_b != logic'(i / 2)) ab_bad++;
        end
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_busy_cycles"}, busy_n, exp_cyc);
    chk({tag, "_ab_sequence_errors"}, ab_bad, 0);
    chk({tag, "_err_count"}, got_err, exp_err);
    chk({tag, "_fail_vec"}, got_fv, exp_fv);
    chk({tag, "_pass"}, got_pass, exp_pass);
    chk({tag, "_pass_held"}, int'(s_pass), exp_pass);
    chk({tag, "_ab_final"}, int'({s_a, s_b}), 3);
    $display("run %s: inst=%0d done@%0d busy=%0d err=%0d fail_vec=%0h pass=%0d",
             tag, which, done_cyc, busy_n, got_err, got_fv, got_pass);
  endtask

  typedef struct {
    string      name;
    logic [5:0] am;
    logic [5:0] om;
    int         err;
    int         fv;
    int         pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int e, fv, p;
    logic       w;
    logic [5:0] am, om;

    tbl[0] = '{"golden",     6'h3F, 6'h00, 0, 4'h0, 1};
    tbl[1] = '{"xor_stuck0", 6'h3D, 6'h00, 2, 4'h6, 0};
    tbl[2] = '{"z_zero",     6'h00, 6'h00, 4, 4'hF, 0};
    tbl[3] = '{"restored",   6'h3F, 6'h00, 0, 4'h0, 1};
    tbl[4] = '{"and_stuck1", 6'h3F, 6'h20, 3, 4'h7, 0};

    // Reset with start asserted
    sel    = 1'b0;
    am0    = 6'h3F; om0 = 6'h00;
    am1    = 6'h3F; om1 = 6'h00;
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0_a", int'(st0.a), 0);
    chk("rst0_b", int'(st0.b), 0);
    chk("rst0_busy", int'(busy0), 0);
    chk("rst0_done", int'(done0), 0);
    chk("rst0_pass", int'(pass0), 0);
    chk("rst0_err", int'(err0), 0);
    chk("rst0_fail_vec", int'(fv0), 0);
    chk("rst1_busy", int'(busy1), 0);
    chk("rst1_done", int'(done1), 0);
    chk("rst1_err", int'(err1), 0);
    $display("reset: a=%0d b=%0d busy=%0d done=%0d pass=%0d err=%0d fail_vec=%0h",
             st0.a, st0.b, busy0, done0, pass0, err0, fv0);
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // Table-driven fault runs on the default-settle instance
    for (int k = 0; k < 5; k++) begin
      am0 = tbl[k].am;
      om0 = tbl[k].om;
      run(1'b0, 4, tbl[k].err, tbl[k].fv, tbl[k].pass, 0, tbl[k].name);
    end

    // Zero-settle instance, with a stray start pulse while busy
    am1 = 6'h3F;
    om1 = 6'h00;
    run(1'b1, 0, 0, 0, 1, 3, "settle0_stray_start");

    // Reset during SETTLE of vector 2 (cycles 14..17), on a failing run
    sel = 1'b0;
    am0 = 6'h00;
    om0 = 6'h00;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (14) @(negedge clk);  // now in cycle 15
    chk("midrst_pre_err", int'(err0), 2);
    chk("midrst_pre_fail_vec", int'(fv0), 3);
    chk("midrst_pre_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_a", int'(st0.a), 0);
    chk("midrst_b", int'(st0.b), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_err", int'(err0), 0);
    chk("midrst_fail_vec", int'(fv0), 0);
    begin
      int dn;
      dn = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done0) dn++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done0) dn++;
      end
      chk("midrst_no_done", dn, 0);
      chk("midrst_post_busy", int'(busy0), 0);
      $display("midrun reset: done pulses after abort=%0d", dn);
    end
    am0 = 6'h3F;
    run(1'b0, 4, 0, 0, 1, 0, "after_midrst");

    // Randomized corruptions checked against the reference model
    for (int k = 0; k < 8; k++) begin
      w  = logic'(k % 2);
      am = ($urandom_range(0, 2) == 0) ? 6'h3F : 6'($urandom);
      om = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      if (w) begin am1 = am; om1 = om; end
      else begin am0 = am; om0 = om; end
      model(am, om, e, fv, p);
      run(w, w ? 0 : 4, e, fv, p, 0, $sformatf("rand%0d_am%0h_om%0h", k, am, om));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
